instruction_fetch: RTL



---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/program_counter.sv | 36 +++
 rtl/instruction_fetch.sv | 96 +++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-side constants and the fetch state type, reusable by decode/control blocks.
package instruction_fetch_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 8;

  localparam logic [ADDR_W-1:0]  RESET_PC    = 8'h00;
  localparam logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF;

  typedef enum logic [0:0] {
    FETCH,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter register: synchronous reset, load has priority over increment, else hold.
module program_counter #(
  parameter int unsigned     Width    = 8,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             incr_i,
  output logic [Width-1:0] pc_o
);

  logic [Width-1:0] pc_q, pc_d;

  // Increment wraps naturally at 2^Width; the carry is dropped.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (incr_i) begin
      pc_d = pc_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= ResetVal;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: drives the PC to a combinational instruction memory, registers the
// returned instruction and hands it to decode over valid/ready; supports redirect and HALT.
module instruction_fetch #(
  parameter int unsigned          ADDR_W      = instruction_fetch_pkg::ADDR_W,
  parameter int unsigned          INSTR_W     = instruction_fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC    = instruction_fetch_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0]   HALT_OPCODE = instruction_fetch_pkg::HALT_OPCODE
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  endereco,
  input  logic [INSTR_W-1:0] instrucao,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               desvio_en,
  input  logic [ADDR_W-1:0]  desvio_alvo,
  output logic               halted
);

  import instruction_fetch_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               branch, capture, is_halt;

  // A redirect outranks capture; both are only honoured while fetching.
  assign is_halt = (instrucao == HALT_OPCODE);
  assign branch  = (state_q == FETCH) && desvio_en;
  assign capture = (state_q == FETCH) && !desvio_en && (!valid_q || instr_ready);

  program_counter #(
    .Width    (ADDR_W),
    .ResetVal (RESET_PC)
  ) u_program_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (branch),
    .load_val_i (desvio_alvo),
    .incr_i     (capture && !is_halt),
    .pc_o       (pc)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    unique case (state_q)
      FETCH: begin
        if (branch) begin
          valid_d = 1'b0;
        end else if (capture) begin
          instr_d  = instrucao;
          pc_out_d = pc;
          valid_d  = 1'b1;
          if (is_halt) begin
            state_d = HALTED;
          end
        end
      end
      HALTED: begin
        // The HALT word stays presented until decode takes it; nothing follows.
        if (instr_ready) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign endereco    = pc;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == HALTED);

endmodule
